// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader into the IMEM write port; `IMEM_LOADER_CSUM_EN adds a trailing XOR checksum
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_enable,
  output logic              done,
  output logic              error
);
  typedef enum logic [1:0] {IDLE, COUNT, DATA, CSUM} state_t;
  state_t state, state_d;
  logic [15:0] idle_cnt;
  logic [7:0] word_idx, last_idx;
  logic [1:0] byte_idx;
  logic [23:0] word;
  logic hdr, tmo, last, done_set, err_set;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] csum;
`else
  logic fin;
`endif
  assign in_ready = 1'b1;
  assign core_enable = (state == IDLE) && !wr_en;
  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_d;
  end
  // next state plus the per-cycle header/timeout/completion events
  always_comb begin
    state_d = state;
    hdr = (state == IDLE) && in_valid && (in_data == HDR_BYTE);
    tmo = (state != IDLE) && !in_valid && (idle_cnt == TIMEOUT);
    last = (byte_idx == 2'd3) && (word_idx == last_idx);
    err_set = tmo;
`ifdef IMEM_LOADER_CSUM_EN
    done_set = 1'b0;
`else
    done_set = fin;
`endif
    case (state)
      IDLE: state_d = hdr ? COUNT : IDLE;
      COUNT: state_d = in_valid ? DATA : COUNT;
`ifdef IMEM_LOADER_CSUM_EN
      DATA: state_d = (in_valid && last) ? CSUM : DATA;
      CSUM: begin
        state_d = in_valid ? IDLE : CSUM;
        done_set = in_valid && (in_data == csum);
        err_set = tmo || (in_valid && (in_data != csum));
      end
`else
      DATA: state_d = (in_valid && last) ? IDLE : DATA;
`endif
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = IDLE;
  end
  // word assembly, IMEM write strobe, idle counter and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en <= 1'b0;
      wr_addr <= BASE_ADDR;
      wr_data <= '0;
      done <= 1'b0;
      error <= 1'b0;
      idle_cnt <= '0;
      word_idx <= '0;
      last_idx <= '0;
      byte_idx <= '0;
      word <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum <= '0;
`else
      fin <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done <= done_set;
      error <= hdr ? 1'b0 : (error || err_set);
      idle_cnt <= (state_d == IDLE || in_valid) ? '0 : idle_cnt + 16'd1;
`ifndef IMEM_LOADER_CSUM_EN
      fin <= (state == DATA) && in_valid && last;
`endif
      if (state == COUNT && in_valid) begin
        last_idx <= in_data - 8'd1;
        word_idx <= '0;
        byte_idx <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum <= '0;
`endif
      end
      if (state == DATA && in_valid) begin
        word <= {word[15:0], in_data};
        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
        csum <= csum ^ in_data;
`endif
        if (byte_idx == 2'd3) begin
          wr_en <= 1'b1;
          wr_data <= {word, in_data};
          wr_addr <= BASE_ADDR + ADDR_W'(word_idx);
          word_idx <= word_idx + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (BASE_ADDR=FE, short TIMEOUT)
module tb_imem_loader;
  localparam logic [7:0] BASE = 8'hFE;
  localparam int TMO = 40;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, wr_en, core_enable, done, error;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;
  int vecs = 0, errs = 0, cyc = 0, done_cnt = 0, both = 0;
  logic [7:0] wa[$];
  logic [31:0] wd[$];
  int wc[$];
  imem_loader #(.ADDR_W(8), .BASE_ADDR(BASE), .TIMEOUT(16'(TMO)), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .core_enable(core_enable),
    .done(done), .error(error)
  );
  always #5 clk = ~clk;
  // write/done log sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst && wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
    if (rst && done) done_cnt++;
    if (done && error) both++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vecs=%0d", vecs);
    $fatal(1);
  end
  task tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task clr;
    wa.delete();
    wd.delete();
    wc.delete();
    done_cnt = 0;
    both = 0;
  endtask
  task test_reset;
    rst = 1'b0;
    tick(2);
    vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    vecs++; if (core_enable !== 1'b1) begin errs++; $display("FAIL rst_core_enable: got %b want 1", core_enable); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL rst_error: got %b want 0", error); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vecs++; if (wr_addr !== BASE) begin errs++; $display("FAIL rst_wr_addr: got %h want %h", wr_addr, BASE); end
    vecs++; if (wr_data !== 32'h0) begin errs++; $display("FAIL rst_wr_data: got %h want 0", wr_data); end
    rst = 1'b1;
    send(8'hA5); send(8'h02); send(8'h20); send(8'h01);
    vecs++; if (core_enable !== 1'b0) begin errs++; $display("FAIL load_core_enable: got %b want 0", core_enable); end
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL midrst_wr_en: got %b want 0", wr_en); end
    vecs++; if (core_enable !== 1'b1) begin errs++; $display("FAIL midrst_core_enable: got %b want 1", core_enable); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL midrst_error: got %b want 0", error); end
  endtask
  task test_frame;
    clr;
    send(8'hA5); send(8'h02); send(8'h20); send(8'h01); send(8'h00); send(8'h05);
    vecs++; if (wr_en !== 1'b1) begin errs++; $display("FAIL w0_wr_en: got %b want 1", wr_en); end
    vecs++; if (wr_addr !== 8'hFE) begin errs++; $display("FAIL w0_addr: got %h want fe", wr_addr); end
    vecs++; if (wr_data !== 32'h20010005) begin errs++; $display("FAIL w0_data: got %h want 20010005", wr_data); end
    send(8'hAC); send(8'h01); send(8'h00); send(8'h00);
    vecs++; if (wr_en !== 1'b1) begin errs++; $display("FAIL w1_wr_en: got %b want 1", wr_en); end
    vecs++; if (wr_addr !== 8'hFF) begin errs++; $display("FAIL w1_addr: got %h want ff", wr_addr); end
    vecs++; if (wr_data !== 32'hAC010000) begin errs++; $display("FAIL w1_data: got %h want ac010000", wr_data); end
    vecs++; if (core_enable !== 1'b0) begin errs++; $display("FAIL lastwr_core_enable: got %b want 0", core_enable); end
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h89);
`else
    tick(1);
`endif
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL frame_done: got %b want 1", done); end
    vecs++; if (core_enable !== 1'b1) begin errs++; $display("FAIL frame_core_enable: got %b want 1", core_enable); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL frame_error: got %b want 0", error); end
    tick(1);
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL done_one_cycle: got %b want 0", done); end
    vecs++; if (wa.size() !== 2) begin errs++; $display("FAIL frame_writes: got %0d want 2", wa.size()); end
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL frame_done_cnt: got %0d want 1", done_cnt); end
  endtask
`ifdef IMEM_LOADER_CSUM_EN
  task test_csum_bad;
    clr;
    send(8'hA5); send(8'h02); send(8'h20); send(8'h01); send(8'h00); send(8'h05);
    send(8'hAC); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL csum_error: got %b want 1", error); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL csum_done: got %b want 0", done); end
    vecs++; if (wa.size() !== 2) begin errs++; $display("FAIL csum_writes: got %0d want 2", wa.size()); end
    send(8'hA5);
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL csum_hdr_clear: got %b want 0", error); end
    send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL csum_recover_done: got %b want 1", done); end
  endtask
`endif
  task test_timeout;
    clr;
    send(8'h11);
    vecs++; if (core_enable !== 1'b1) begin errs++; $display("FAIL junk_core_enable: got %b want 1", core_enable); end
    send(8'hA5); send(8'h01); send(8'hAB);
    tick(TMO);
    send(8'hCD);
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL tmo_edge_error: got %b want 0", error); end
    vecs++; if (core_enable !== 1'b0) begin errs++; $display("FAIL tmo_edge_core: got %b want 0", core_enable); end
    tick(TMO + 1);
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL tmo_error: got %b want 1", error); end
    vecs++; if (core_enable !== 1'b1) begin errs++; $display("FAIL tmo_core_enable: got %b want 1", core_enable); end
    vecs++; if (wa.size() !== 0) begin errs++; $display("FAIL tmo_writes: got %0d want 0", wa.size()); end
    vecs++; if (done_cnt !== 0) begin errs++; $display("FAIL tmo_done: got %0d want 0", done_cnt); end
    send(8'hA5);
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL tmo_hdr_clear: got %b want 0", error); end
    send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h44);
`endif
    tick(2);
    vecs++; if (wa.size() !== 1) begin errs++; $display("FAIL tmo_recover_writes: got %0d want 1", wa.size()); end
    vecs++; if (wd[0] !== 32'h11223344) begin errs++; $display("FAIL tmo_recover_data: got %h want 11223344", wd[0]); end
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL tmo_recover_done: got %0d want 1", done_cnt); end
  endtask
  task test_wrap;
    clr;
    send(8'hA5); send(8'h03);
    for (int i = 1; i <= 12; i++) send(8'(i));
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h0C);
`endif
    tick(2);
    vecs++; if (wa.size() !== 3) begin errs++; $display("FAIL wrap_writes: got %0d want 3", wa.size()); end
    vecs++; if (wa[0] !== 8'hFE) begin errs++; $display("FAIL wrap_addr0: got %h want fe", wa[0]); end
    vecs++; if (wa[1] !== 8'hFF) begin errs++; $display("FAIL wrap_addr1: got %h want ff", wa[1]); end
    vecs++; if (wa[2] !== 8'h00) begin errs++; $display("FAIL wrap_addr2: got %h want 00", wa[2]); end
    vecs++; if (wd[2] !== 32'h090A0B0C) begin errs++; $display("FAIL wrap_data2: got %h want 090a0b0c", wd[2]); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL wrap_error: got %b want 0", error); end
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
  endtask
  task test_back_to_back;
    int bad_a, bad_d, bad_s;
    clr;
    bad_a = 0;
    bad_d = 0;
    bad_s = 0;
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 1024; i++) begin
      send(8'(i));
      if (i == 500) begin
        vecs++; if (core_enable !== 1'b0) begin errs++; $display("FAIL b2b_core_mid: got %b want 0", core_enable); end
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h00);
`endif
    tick(3);
    vecs++; if (wa.size() !== 256) begin errs++; $display("FAIL b2b_writes: got %0d want 256", wa.size()); end
    for (int k = 0; k < wa.size(); k++) begin
      if (wa[k] !== 8'(BASE + k)) bad_a++;
      if (wd[k] !== {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)}) bad_d++;
      if (k > 0 && wc[k] - wc[k-1] != 4) bad_s++;
    end
    vecs++; if (bad_a !== 0) begin errs++; $display("FAIL b2b_addr: got %0d bad want 0", bad_a); end
    vecs++; if (bad_d !== 0) begin errs++; $display("FAIL b2b_data: got %0d bad want 0", bad_d); end
    vecs++; if (bad_s !== 0) begin errs++; $display("FAIL b2b_spacing: got %0d bad want 0", bad_s); end
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
    vecs++; if (core_enable !== 1'b1) begin errs++; $display("FAIL b2b_core_end: got %b want 1", core_enable); end
    vecs++; if (both !== 0) begin errs++; $display("FAIL done_and_error: got %0d want 0", both); end
  endtask
  initial begin
    test_reset;
    test_frame;
`ifdef IMEM_LOADER_CSUM_EN
    test_csum_bad;
`endif
    test_timeout;
    test_wrap;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
